// File: rtl/seq_det_pkg.sv
// Shared defaults and FSM state encoding for the serial "1000" detector scheduler.
// Pure constants: no latency, no flow control.
package seq_det_pkg;

    localparam int NREQ_DEF    = 4;
    localparam int W_DEF       = 8;
    localparam int DET_LAT_DEF = 2;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CLR   = 3'd1,
        ST_SHIFT = 3'd2,
        ST_DRAIN = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin pick: first requester after the last granted index, one-hot out.
// Combinational, zero latency; no backpressure (grant is only a suggestion to the caller).
module rr_arbiter
    import seq_det_pkg::*;
#(
    parameter int NREQ = NREQ_DEF,
    parameter int PW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic [NREQ-1:0] req,
    input  logic [PW-1:0]   last,
    output logic [NREQ-1:0] gnt
);

    int   idx;
    logic found;

    // Walk last+1 .. last+NREQ with wrap; the first asserted request wins.
    always_comb begin
        gnt   = '0;
        found = 1'b0;
        idx   = 0;
        for (int i = 1; i <= NREQ; i++) begin
            idx = int'(last) + i;
            if (idx >= NREQ) idx = idx - NREQ;
            if (!found && req[idx[PW-1:0]]) begin
                gnt[idx[PW-1:0]] = 1'b1;
                found            = 1'b1;
            end
        end
    end

endmodule

// File: rtl/seq_det_sched.sv
// Time-shares one serial "1000" detector among NREQ requesters, one word per grant.
// Latency: done W+DET_LAT+1 cycles after gnt rises; requesters simply wait while busy.
module seq_det_sched
    import seq_det_pkg::*;
#(
    parameter int NREQ    = NREQ_DEF,
    parameter int W       = W_DEF,
    parameter int DET_LAT = DET_LAT_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NREQ-1:0]   req,
    input  logic [NREQ*W-1:0] data,
    output logic [NREQ-1:0]   gnt,
    output logic [NREQ-1:0]   done,
    output logic              hit,
    output logic              busy,
    output logic              det_rst_n,
    output logic              det_a,
    input  logic              det_y
);

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int CW = $clog2(W + DET_LAT + 1);
    localparam logic [CW-1:0] SHIFT_LAST = CW'(W - 1);
    localparam logic [CW-1:0] DRAIN_LAST = CW'(W + DET_LAT - 1);
    localparam logic [CW-1:0] WIN_FIRST  = CW'(DET_LAT);

    state_t          state;
    state_t          nxt;
    logic [NREQ-1:0] arb_gnt;
    logic [NREQ-1:0] gnt_q;
    logic [PW-1:0]   last;
    logic [PW-1:0]   sel_idx;
    logic [W-1:0]    sel_word;
    logic [W-1:0]    sreg;
    logic [CW-1:0]   cnt;
    logic            acc;
    logic            grant;

    rr_arbiter #(
        .NREQ (NREQ),
        .PW   (PW)
    ) u_arb (
        .req  (req),
        .last (last),
        .gnt  (arb_gnt)
    );

    always_comb begin
        sel_idx  = '0;
        sel_word = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (arb_gnt[i]) begin
                sel_idx  = PW'(i);
                sel_word = data[i*W +: W];
            end
        end
    end

    assign grant = (state == ST_IDLE) && (req != '0);
    assign gnt   = gnt_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= ST_IDLE;
        else      state <= nxt;
    end

    always_comb begin
        nxt = state;
        case (state)
            ST_IDLE:  if (grant) nxt = ST_CLR;
            ST_CLR:   nxt = ST_SHIFT;
            ST_SHIFT: if (cnt == SHIFT_LAST) nxt = (DET_LAT == 0) ? ST_DONE : ST_DRAIN;
            ST_DRAIN: if (cnt == DRAIN_LAST) nxt = ST_DONE;
            ST_DONE:  nxt = ST_IDLE;
            default:  nxt = ST_IDLE;
        endcase
    end

    // cnt runs continuously through SHIFT and DRAIN, so the hit window is simply cnt >= DET_LAT.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            gnt_q <= '0;
            last  <= PW'(NREQ - 1);
            sreg  <= '0;
            cnt   <= '0;
            acc   <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (grant) begin
                        gnt_q <= arb_gnt;
                        last  <= sel_idx;
                        sreg  <= sel_word;
                    end
                end
                ST_CLR: begin
                    cnt <= '0;
                    acc <= 1'b0;
                end
                ST_SHIFT, ST_DRAIN: begin
                    sreg <= sreg << 1;
                    cnt  <= cnt + CW'(1);
                    if (cnt >= WIN_FIRST) acc <= acc | det_y;
                end
                ST_DONE: gnt_q <= '0;
                default: ;
            endcase
        end
    end

    always_comb begin
        det_a     = 1'b0;
        det_rst_n = rst;
        done      = '0;
        hit       = 1'b0;
        busy      = 1'b1;
        case (state)
            ST_IDLE:  busy = 1'b0;
            ST_CLR:   det_rst_n = 1'b0;
            ST_SHIFT: det_a = sreg[W-1];
            ST_DONE: begin
                done = gnt_q;
                hit  = acc;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_seq_det_sched.sv
// Bench for seq_det_sched: "1000" Moore detector model on det_a/det_y, expected
// completions queued by the stimulus and matched by an independent monitor.
module tb_seq_det_sched;

    localparam int NREQ    = 4;
    localparam int W       = 8;
    localparam int DET_LAT = 2;
    localparam int LAT     = W + DET_LAT + 1;
    localparam int PERIOD  = W + DET_LAT + 3;

    typedef struct packed {
        logic [NREQ-1:0] d;
        logic            h;
    } exp_t;

    logic              clk  = 1'b0;
    logic              rst  = 1'b0;
    logic [NREQ-1:0]   req  = '0;
    logic [NREQ*W-1:0] data = '0;
    logic              det_y;
    logic [NREQ-1:0]   gnt;
    logic [NREQ-1:0]   done;
    logic              hit;
    logic              busy;
    logic              det_rst_n;
    logic              det_a;

    int   errors = 0;
    int   checks = 0;
    int   cyc    = 0;
    int   rises  = 0;
    int   last_rise = 0;
    bit   chk_period = 1'b0;
    bit   prd_valid  = 1'b0;
    exp_t q[$];
    exp_t e;
    logic [NREQ-1:0] prev_gnt = '0;
    logic [2:0]      dst;
    int   r0;

    seq_det_sched #(.NREQ(NREQ), .W(W), .DET_LAT(DET_LAT)) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .data      (data),
        .gnt       (gnt),
        .done      (done),
        .hit       (hit),
        .busy      (busy),
        .det_rst_n (det_rst_n),
        .det_a     (det_a),
        .det_y     (det_y)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Detector: state 4 means "1000" just seen; det_y is that state registered (2-cycle latency).
    always @(posedge clk) begin
        if (!det_rst_n) begin
            dst   <= 3'd0;
            det_y <= 1'b0;
        end else begin
            det_y <= (dst == 3'd4);
            if (det_a) dst <= 3'd1;
            else begin
                case (dst)
                    3'd1:    dst <= 3'd2;
                    3'd2:    dst <= 3'd3;
                    3'd3:    dst <= 3'd4;
                    default: dst <= 3'd0;
                endcase
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic set_word(input int i, input logic [W-1:0] v);
        data[i*W +: W] = v;
    endtask

    task automatic wait_gnt(input string name);
        int t = 0;
        while (gnt == '0 && t < 50) begin
            @(posedge clk); #1;
            t++;
        end
        check(name, 32'(gnt != '0), 1);
    endtask

    task automatic wait_rises(input int target, input string name);
        int t = 0;
        while (rises < target && t < 200) begin
            @(posedge clk); #1;
            t++;
        end
        check(name, 32'(rises >= target), 1);
    endtask

    task automatic wait_idle(input string name);
        int t = 0;
        while ((q.size() != 0 || busy) && t < 300) begin
            @(posedge clk); #1;
            t++;
        end
        check(name, 32'(q.size() == 0 && !busy), 1);
    endtask

    // Monitor: tracks grant edges and consumes one expectation per done pulse.
    initial begin
        forever begin
            @(negedge clk);
            if (gnt != '0 && prev_gnt == '0) begin
                check("gnt_onehot", 32'($onehot(gnt)), 1);
                if (chk_period && prd_valid) check("gnt_period", cyc - last_rise, PERIOD);
                prd_valid = chk_period;
                last_rise = cyc;
                rises++;
            end
            prev_gnt = gnt;
            if (done != '0) begin
                if (q.size() == 0) check("unexpected_done", 32'(done), 0);
                else begin
                    e = q.pop_front();
                    check("done_vec", 32'(done), 32'(e.d));
                    check("hit", 32'(hit), 32'(e.h));
                    check("done_latency", cyc - last_rise, LAT);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1);
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check("rst_gnt", 32'(gnt), 0);
        check("rst_done", 32'(done), 0);
        check("rst_hit", 32'(hit), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_det_a", 32'(det_a), 0);
        check("rst_det_rst_n", 32'(det_rst_n), 0);
        @(negedge clk) rst = 1'b1;
        @(posedge clk); #1;

        // Single requester: match, drain-only match, no match.
        set_word(0, 8'b0100_0101);
        q.push_back('{d: 4'b0001, h: 1'b1});
        req = 4'b0001;
        wait_gnt("t1_gnt_wait");
        check("t1_gnt", 32'(gnt), 32'(4'b0001));
        req = '0;
        wait_idle("t1_idle");

        set_word(0, 8'b0000_0001);
        q.push_back('{d: 4'b0001, h: 1'b0});
        req = 4'b0001;
        wait_gnt("t2_gnt_wait");
        req = '0;
        wait_idle("t2_idle");

        set_word(0, 8'b1010_1001);
        q.push_back('{d: 4'b0001, h: 1'b0});
        req = 4'b0001;
        wait_gnt("t3_gnt_wait");
        req = '0;
        wait_idle("t3_idle");

        // Fresh pointer, then full contention: 0,1,2,3,0.
        @(negedge clk) rst = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk) rst = 1'b1;
        @(posedge clk); #1;
        set_word(0, 8'b0100_0101);
        set_word(1, 8'b0000_0001);
        set_word(2, 8'b1000_0000);
        set_word(3, 8'b1010_1001);
        q.push_back('{d: 4'b0001, h: 1'b1});
        q.push_back('{d: 4'b0010, h: 1'b0});
        q.push_back('{d: 4'b0100, h: 1'b1});
        q.push_back('{d: 4'b1000, h: 1'b0});
        q.push_back('{d: 4'b0001, h: 1'b1});
        chk_period = 1'b1;
        r0 = rises;
        req = 4'b1111;
        wait_rises(r0 + 5, "t4_rises");
        req = '0;
        chk_period = 1'b0;
        wait_idle("t4_idle");

        // req[2] withdrawn mid-shift; requester 3 must be next, 2 never again.
        q.push_back('{d: 4'b0100, h: 1'b1});
        q.push_back('{d: 4'b1000, h: 1'b0});
        r0 = rises;
        req = 4'b0100;
        wait_gnt("t5_gnt_wait");
        repeat (3) @(posedge clk);
        #1;
        req = 4'b1000;
        wait_rises(r0 + 2, "t5_rises");
        req = '0;
        wait_idle("t5_idle");

        // Reset in SHIFT cycle 3 aborts silently.
        req = 4'b0001;
        wait_gnt("t6_gnt_wait");
        check("t6_gnt", 32'(gnt), 32'(4'b0001));
        repeat (4) @(posedge clk);
        #1;
        check("t6_busy_pre", 32'(busy), 1);
        rst = 1'b0;
        #1;
        check("t6_abort_gnt", 32'(gnt), 0);
        check("t6_abort_busy", 32'(busy), 0);
        check("t6_abort_det_rst_n", 32'(det_rst_n), 0);
        check("t6_abort_done", 32'(done), 0);
        req = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        req = 4'b0100;
        q.push_back('{d: 4'b0100, h: 1'b1});
        @(posedge clk); #1;
        check("t6_first_gnt", 32'(gnt), 32'(4'b0100));
        req = '0;
        wait_idle("t6_idle");

        // Back-to-back on requester 1; data changed after the first grant.
        set_word(1, 8'b1000_0000);
        q.push_back('{d: 4'b0010, h: 1'b1});
        q.push_back('{d: 4'b0010, h: 1'b0});
        chk_period = 1'b1;
        r0 = rises;
        req = 4'b0010;
        wait_gnt("t7_gnt_wait");
        set_word(1, 8'b0000_0000);
        wait_rises(r0 + 2, "t7_rises");
        req = '0;
        chk_period = 1'b0;
        wait_idle("t7_idle");

        repeat (20) @(posedge clk);
        #1;
        check("end_queue_empty", 32'(q.size()), 0);
        check("end_gnt", 32'(gnt), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
